controle_irrigacao: RTL and testbench



---
 rtl/controle_irrigacao.sv | 161 ++++++++++++++++
 tb/tb_controle_irrigacao.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/controle_irrigacao.sv
// rtl/controle_irrigacao.sv - tank fill and drip/sprinkler valve controller (optional fill watchdog: IRRIG_TIMEOUT_EN)
module controle_irrigacao #(
    parameter int DEB_CYC  = 4,
    parameter int T_MIN    = 16,
    parameter int T_MORTO  = 4,
    parameter int T_ENCHER = 1024,
    parameter int CNT_W    = 11
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       Alta,
    input  logic       Media,
    input  logic       Baixa,
    input  logic       req_goteja,
    input  logic       req_asper,
    input  logic       limpa_erro,
    output logic       Ve,
    output logic       Gotejamento,
    output logic       Aspersao,
    output logic       Alarme,
    output logic       Erro,
    output logic [2:0] estado
);
    localparam int DW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;

    typedef enum logic [2:0] {
        OCIOSO = 3'd0,
        GOTEJA = 3'd1,
        ASPER  = 3'd2,
        MORTO  = 3'd3,
        FALHA  = 3'd4
    } estado_t;

    logic [2:0]          raw;
    logic [2:0]          deb;
    logic [2:0][DW-1:0]  deb_cnt;
    logic                alta_d, media_d, baixa_d;
    logic                incons, wd_exp, err_set;
    estado_t             st, nxt;
    logic [CNT_W-1:0]    tmr;

    assign raw     = {Alta, Media, Baixa};
    assign alta_d  = deb[2];
    assign media_d = deb[1];
    assign baixa_d = deb[0];
    assign incons  = (alta_d & ~media_d) | (media_d & ~baixa_d);
    assign err_set = incons | wd_exp;
    assign estado  = st;

    // A sensor flips only after DEB_CYC consecutive samples disagreeing with it
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            deb     <= '0;
            deb_cnt <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (raw[i] == deb[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DW'(DEB_CYC - 1)) begin
                    deb[i]     <= raw[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
        end
    end

`ifdef IRRIG_TIMEOUT_EN
    logic [2:0]       deb_q;
    logic [CNT_W-1:0] wd_cnt;
    logic             rise;

    assign rise   = |(deb & ~deb_q);
    assign wd_exp = Ve && (wd_cnt == CNT_W'(T_ENCHER));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            deb_q  <= '0;
            wd_cnt <= '0;
        end else begin
            deb_q <= deb;
            if (!Ve || rise)
                wd_cnt <= '0;
            else if (!wd_exp)
                wd_cnt <= wd_cnt + 1'b1;
        end
    end
`else
    assign wd_exp = 1'b0;
`endif

    // Next-state uses the debounced level directly so the registered Alarme lag never opens a valve
    always_comb begin
        nxt = st;
        case (st)
            OCIOSO: begin
                if (Erro || err_set)   nxt = FALHA;
                else if (!baixa_d)     nxt = OCIOSO;
                else if (req_asper)    nxt = ASPER;
                else if (req_goteja)   nxt = GOTEJA;
            end
            GOTEJA: begin
                if (Erro || err_set)   nxt = FALHA;
                else if (!baixa_d)     nxt = MORTO;
                else if ((!req_goteja || req_asper) && tmr >= CNT_W'(T_MIN - 1))
                    nxt = MORTO;
            end
            ASPER: begin
                if (Erro || err_set)   nxt = FALHA;
                else if (!baixa_d)     nxt = MORTO;
                else if (!req_asper && tmr >= CNT_W'(T_MIN - 1))
                    nxt = MORTO;
            end
            MORTO: begin
                if (Erro || err_set)   nxt = FALHA;
                else if (tmr >= CNT_W'(T_MORTO - 1))
                    nxt = OCIOSO;
            end
            FALHA: begin
                if (limpa_erro && !err_set) nxt = OCIOSO;
            end
            default: nxt = OCIOSO;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st          <= OCIOSO;
            tmr         <= '0;
            Gotejamento <= 1'b0;
            Aspersao    <= 1'b0;
            Erro        <= 1'b0;
            Alarme      <= 1'b0;
            Ve          <= 1'b0;
        end else begin
            st          <= nxt;
            Gotejamento <= (nxt == GOTEJA);
            Aspersao    <= (nxt == ASPER);
            Alarme      <= ~baixa_d;

            if (nxt != st)
                tmr <= '0;
            else if (tmr != '1)
                tmr <= tmr + 1'b1;

            if (err_set)
                Erro <= 1'b1;
            else if (st == FALHA && nxt == OCIOSO)
                Erro <= 1'b0;

            // Hysteresis: open below Media, close at Alta; any fault keeps it shut
            if (Erro || err_set || st == FALHA)
                Ve <= 1'b0;
            else if (alta_d)
                Ve <= 1'b0;
            else if (!media_d)
                Ve <= 1'b1;
        end
    end
endmodule

// File: tb/tb_controle_irrigacao.sv
// tb/tb_controle_irrigacao.sv - directed self-checking bench for controle_irrigacao (watchdog steps under IRRIG_TIMEOUT_EN)
module tb_controle_irrigacao;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       Alta, Media, Baixa;
    logic       req_goteja, req_asper, limpa_erro;
    logic       Ve, Gotejamento, Aspersao, Alarme, Erro;
    logic [2:0] estado;
    int         errors = 0;
    int         checks = 0;

    controle_irrigacao dut (
        .clk(clk), .rst_n(rst_n),
        .Alta(Alta), .Media(Media), .Baixa(Baixa),
        .req_goteja(req_goteja), .req_asper(req_asper), .limpa_erro(limpa_erro),
        .Ve(Ve), .Gotejamento(Gotejamento), .Aspersao(Aspersao),
        .Alarme(Alarme), .Erro(Erro), .estado(estado)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; Alta = 1'b0; Media = 1'b0; Baixa = 1'b0;
        req_goteja = 1'b0; req_asper = 1'b1; limpa_erro = 1'b0;
        step(2);
        chk("rst_ve", Ve, 0);
        chk("rst_goteja", Gotejamento, 0);
        chk("rst_asper", Aspersao, 0);
        chk("rst_alarme", Alarme, 0);
        chk("rst_erro", Erro, 0);
        chk("rst_estado", estado, 0);

        rst_n = 1'b1;
        step(1);
        chk("rel_asper", Aspersao, 0);
        chk("rel_alarme", Alarme, 1);
        chk("rel_ve", Ve, 1);
        chk("rel_estado", estado, 0);

        req_asper = 1'b0; Baixa = 1'b1; Media = 1'b1;
        step(5);
        chk("fill_alarme", Alarme, 0);
        chk("fill_erro", Erro, 0);
        chk("fill_ve_hold", Ve, 1);
        Alta = 1'b1;
        step(4);
        chk("alta_deb_ve", Ve, 1);
        step(1);
        chk("alta_ve_off", Ve, 0);
        Alta = 1'b0;
        step(5);
        chk("hyst_ve", Ve, 0);
        chk("hyst_erro", Erro, 0);

        req_goteja = 1'b1;
        step(1);
        chk("got_on", Gotejamento, 1);
        chk("got_estado", estado, 1);
        step(2);
        req_goteja = 1'b0;
        step(13);
        chk("got_tmin_last", Gotejamento, 1);
        step(1);
        chk("got_off", Gotejamento, 0);
        chk("got_morto", estado, 3);
        step(3);
        chk("morto_last", estado, 3);
        step(1);
        chk("morto_exit", estado, 0);

        req_goteja = 1'b1;
        step(1);
        chk("sw_got_on", Gotejamento, 1);
        step(1);
        req_asper = 1'b1;
        step(14);
        chk("sw_got_hold", Gotejamento, 1);
        chk("sw_asp_wait", Aspersao, 0);
        step(1);
        chk("sw_got_off", Gotejamento, 0);
        chk("sw_morto", estado, 3);
        step(4);
        chk("sw_ocioso", estado, 0);
        chk("sw_asp_gap", Aspersao, 0);
        step(1);
        chk("sw_asp_on", Aspersao, 1);
        chk("sw_asp_estado", estado, 2);
        req_goteja = 1'b0;

        Baixa = 1'b0;
        step(3);
        Baixa = 1'b1;
        step(2);
        chk("glitch_alarme", Alarme, 0);
        chk("glitch_asp", Aspersao, 1);
        chk("glitch_erro", Erro, 0);

        Baixa = 1'b0; Media = 1'b0;
        step(4);
        chk("low_deb_asp", Aspersao, 1);
        chk("low_deb_alarme", Alarme, 0);
        step(1);
        chk("low_alarme", Alarme, 1);
        chk("low_asp_off", Aspersao, 0);
        chk("low_morto", estado, 3);
        chk("low_erro", Erro, 0);
        chk("low_ve", Ve, 1);
        step(5);
        chk("alarm_idle", estado, 0);
        chk("alarm_no_asp", Aspersao, 0);
        req_asper = 1'b0;

        Alta = 1'b1; Baixa = 1'b1;
        step(4);
        chk("inc_deb_erro", Erro, 0);
        step(1);
        chk("inc_erro", Erro, 1);
        chk("inc_falha", estado, 4);
        chk("inc_ve", Ve, 0);
        limpa_erro = 1'b1;
        step(2);
        chk("inc_limpa_stay", estado, 4);
        chk("inc_limpa_erro", Erro, 1);
        Media = 1'b1;
        step(4);
        chk("fix_deb_stay", estado, 4);
        step(1);
        chk("fix_ocioso", estado, 0);
        chk("fix_erro", Erro, 0);
        limpa_erro = 1'b0;

        req_goteja = 1'b1;
        step(1);
        chk("mid_got_on", Gotejamento, 1);
        rst_n = 1'b0;
        step(1);
        chk("mid_rst_got", Gotejamento, 0);
        chk("mid_rst_estado", estado, 0);
        chk("mid_rst_ve", Ve, 0);
        Alta = 1'b0; Media = 1'b0; Baixa = 1'b0; req_goteja = 1'b0;
        step(1);
        rst_n = 1'b1;
        step(1);
        chk("wd_ve_on", Ve, 1);
`ifdef IRRIG_TIMEOUT_EN
        step(1024);
        chk("wd_pre_erro", Erro, 0);
        chk("wd_pre_ve", Ve, 1);
        step(1);
        chk("wd_erro", Erro, 1);
        chk("wd_ve_off", Ve, 0);
        chk("wd_falha", estado, 4);
`else
        step(1029);
        chk("nowd_erro", Erro, 0);
        chk("nowd_ve", Ve, 1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
